// File: rtl/cpu_pkg.sv
// Shared types for the hardwired control unit: opcode map, control steps,
// instruction classes and the bundled strobe word.
package cpu_pkg;

    typedef enum logic [4:0] {
        OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
        OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101,
        OP_SHL  = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
        OP_AND  = 5'b01001, OP_OR   = 5'b01010, OP_ADDI = 5'b01011,
        OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110,
        OP_DIV  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001,
        OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_IN   = 5'b10101,
        OP_OUT  = 5'b10110, OP_MFHI = 5'b10111, OP_MFLO = 5'b11000,
        OP_NOP  = 5'b11001, OP_HALT = 5'b11010
    } op_t;

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_t;

    typedef enum logic [3:0] {
        CLS_LD, CLS_LDI, CLS_ST, CLS_ALU3, CLS_ALUI, CLS_MULDIV,
        CLS_UNARY, CLS_BR, CLS_SINGLE, CLS_NOP, CLS_HALT
    } cls_t;

    typedef struct packed {
        logic read, write, inc_pc;
        logic gra, grb, grc, rin, rout, ba_out;
        logic hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in;
        logic inport_in, outport_in, con_in;
        logic hi_out, lo_out, y_out, zhigh_out, zlow_out, pc_out;
        logic mar_out, mdr_out, inport_out, outport_out, c_out;
    } ctrl_t;

    // Final control step of each class; the sequencer wraps to T0 after it.
    function automatic step_t last_step(input cls_t c);
        case (c)
            CLS_LD, CLS_ST:                  return T7;
            CLS_LDI, CLS_ALU3, CLS_ALUI:     return T5;
            CLS_MULDIV, CLS_BR:              return T6;
            CLS_UNARY:                       return T4;
            default:                         return T3;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_op_classify.sv
// Maps a 5-bit instruction opcode to its control-sequence class.
module op_classify
    import cpu_pkg::*;
(
    input  logic [4:0] op,
    output cls_t       cls
);

    always_comb begin
        cls = CLS_NOP;
        case (op)
            OP_LD:                                   cls = CLS_LD;
            OP_LDI:                                  cls = CLS_LDI;
            OP_ST:                                   cls = CLS_ST;
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:           cls = CLS_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:                cls = CLS_ALUI;
            OP_MUL, OP_DIV:                          cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                          cls = CLS_UNARY;
            OP_BR:                                   cls = CLS_BR;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:  cls = CLS_SINGLE;
            OP_HALT:                                 cls = CLS_HALT;
            default:                                 cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired micro-sequencer: fetch, decode IR opcode, and drive one control
// step of datapath strobes per clock.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned IR_W = 32
) (
    input  logic            Clock,
    input  logic            clear,
    input  logic [IR_W-1:0] IR,
    input  logic            CON_FF,
    output logic            Run,
    output logic [4:0]      opcode,
    output logic            Read, Write, IncPC,
    output logic            Gra, Grb, Grc, Rin, Rout, BAout,
    output logic            HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin,
    output logic            Inportin, Outportin, CONin,
    output logic            HIout, LOout, Yout, Zhighout, Zlowout, PCout,
    output logic            MARout, MDRout, Inportout, Outportout, Cout
);

    step_t      step_q, step_d;
    logic       halt_q, halt_d;
    cls_t       cls;
    ctrl_t      c;
    logic [4:0] alu_op, imm_op, ir_op;
    logic       en;
    logic       unused_ir_low;

    assign ir_op         = IR[IR_W-1 -: 5];
    assign unused_ir_low = ^IR[IR_W-6:0];

    op_classify u_classify (.op(ir_op), .cls(cls));

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            step_q <= T0;
            halt_q <= 1'b0;
        end else begin
            step_q <= step_d;
            halt_q <= halt_d;
        end
    end

    // Once halted, the step counter freezes; only clear leaves HALT.
    always_comb begin
        step_d = step_q;
        halt_d = halt_q;
        if (!halt_q) begin
            if (step_q == T3 && cls == CLS_HALT)
                halt_d = 1'b1;
            else if (step_q == last_step(cls))
                step_d = T0;
            else
                step_d = step_t'(step_q + 3'd1);
        end
    end

    always_comb begin
        case (ir_op)
            OP_ADDI: imm_op = OP_ADD;
            OP_ANDI: imm_op = OP_AND;
            default: imm_op = OP_OR;
        endcase
    end

    always_comb begin
        c      = '0;
        alu_op = '0;
        case (step_q)
            T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
            T1: begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
            T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            T3: case (cls)
                CLS_LD, CLS_LDI, CLS_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
                CLS_ALU3, CLS_ALUI:      begin c.grb = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
                CLS_MULDIV:              begin c.gra = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
                CLS_UNARY: begin
                    c.grb = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; alu_op = ir_op;
                end
                CLS_BR:                  begin c.gra = 1'b1; c.rout = 1'b1; c.con_in = 1'b1; end
                CLS_SINGLE: case (ir_op)
                    OP_JR:   begin c.gra = 1'b1; c.rout = 1'b1; c.pc_in = 1'b1; end
                    OP_IN:   begin c.inport_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    OP_OUT:  begin c.gra = 1'b1; c.rout = 1'b1; c.outport_in = 1'b1; end
                    OP_MFHI: begin c.hi_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    OP_MFLO: begin c.lo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                    default: ;
                endcase
                default: ;
            endcase
            T4: case (cls)
                CLS_LD, CLS_LDI, CLS_ST: begin c.c_out = 1'b1; c.z_in = 1'b1; alu_op = OP_ADD; end
                CLS_ALU3:   begin c.grc = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; alu_op = ir_op; end
                CLS_ALUI:   begin c.c_out = 1'b1; c.z_in = 1'b1; alu_op = imm_op; end
                CLS_MULDIV: begin c.grb = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; alu_op = ir_op; end
                CLS_UNARY:  begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                CLS_BR:     begin c.pc_out = 1'b1; c.y_in = 1'b1; end
                default: ;
            endcase
            T5: case (cls)
                CLS_LD, CLS_ST:               begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
                CLS_LDI, CLS_ALU3, CLS_ALUI:  begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                CLS_MULDIV:                   begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
                CLS_BR: begin c.c_out = 1'b1; c.z_in = 1'b1; alu_op = OP_ADD; end
                default: ;
            endcase
            T6: case (cls)
                CLS_LD:     begin c.read = 1'b1; c.mdr_in = 1'b1; end
                CLS_ST:     begin c.gra = 1'b1; c.rout = 1'b1; c.mdr_in = 1'b1; end
                CLS_MULDIV: begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
                CLS_BR:     begin c.zlow_out = CON_FF; c.pc_in = CON_FF; end
                default: ;
            endcase
            T7: case (cls)
                CLS_LD:  begin c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                CLS_ST:  c.write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

    // clear gates outputs combinationally so reset takes effect without an edge.
    assign en  = clear & ~halt_q;
    assign Run = en & ~(step_q == T3 && cls == CLS_HALT);

    assign opcode     = en ? alu_op : '0;
    assign Read       = en & c.read;
    assign Write      = en & c.write;
    assign IncPC      = en & c.inc_pc;
    assign Gra        = en & c.gra;
    assign Grb        = en & c.grb;
    assign Grc        = en & c.grc;
    assign Rin        = en & c.rin;
    assign Rout       = en & c.rout;
    assign BAout      = en & c.ba_out;
    assign HIin       = en & c.hi_in;
    assign LOin       = en & c.lo_in;
    assign Yin        = en & c.y_in;
    assign Zin        = en & c.z_in;
    assign PCin       = en & c.pc_in;
    assign IRin       = en & c.ir_in;
    assign MARin      = en & c.mar_in;
    assign MDRin      = en & c.mdr_in;
    assign Inportin   = en & c.inport_in;
    assign Outportin  = en & c.outport_in;
    assign CONin      = en & c.con_in;
    assign HIout      = en & c.hi_out;
    assign LOout      = en & c.lo_out;
    assign Yout       = en & c.y_out;
    assign Zhighout   = en & c.zhigh_out;
    assign Zlowout    = en & c.zlow_out;
    assign PCout      = en & c.pc_out;
    assign MARout     = en & c.mar_out;
    assign MDRout     = en & c.mdr_out;
    assign Inportout  = en & c.inport_out;
    assign Outportout = en & c.outport_out;
    assign Cout       = en & c.c_out;

endmodule
